// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: fetch FSM states and the
// sequential fetch stride.
package instr_fetch_queue_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} entries; the head is read
// combinationally and clear empties it in one cycle.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         clear,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Guard against overflow and underflow regardless of the caller.
   always_comb begin
      push_ok_s = push && (count_r != FULL_C);
      pop_ok_s  = pop && (count_r != {CW{1'b0}});
   end

   // Pointers and occupancy; clear wins over push and pop.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage, not reset: contents are only observed while occupied.
   always_ff @(posedge clk) begin
      if (nrst && !clear && push_ok_s) mem_r[wr_ptr_r] <= push_data;
   end

   assign head_data = mem_r[rd_ptr_r];
   assign count     = count_r;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one outstanding word fetch at a time, buffers
// returned words with their PC, and handles branch redirects by flushing.
module instr_fetch_queue
   import instr_fetch_queue_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         nrst,
   output logic                         imem_req,
   output logic [XLEN-1:0]              imem_addr,
   input  logic                         imem_ack,
   input  logic [31:0]                  imem_rdata,
   output logic                         instr_valid,
   output logic [31:0]                  instr,
   output logic [XLEN-1:0]              instr_pc,
   input  logic                         instr_ready,
   input  logic                         flush,
   input  logic [XLEN-1:0]              flush_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW:0]   FULL_X = (CW+1)'(DEPTH);

   fetch_state_e      state_r;
   fetch_state_e      state_nxt_s;
   logic [XLEN-1:0]   fetch_pc_r;
   logic [XLEN-1:0]   drop_addr_r;
   logic [CW-1:0]     fifo_count_s;
   logic [31+XLEN:0]  head_s;
   logic              push_s;
   logic              pop_s;
   logic              valid_s;
   logic [CW:0]       post_cnt_s;

   fetch_fifo #(
      .WIDTH (32 + XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .clear     (flush),
      .push      (push_s),
      .push_data ({imem_rdata, fetch_pc_r}),
      .pop       (pop_s),
      .head_data (head_s),
      .count     (fifo_count_s)
   );

   // Queue handshakes and the occupancy that results from this cycle's push.
   always_comb begin
      valid_s    = (fifo_count_s != {CW{1'b0}});
      pop_s      = valid_s && instr_ready && !flush;
      push_s     = (state_r == ST_REQ) && imem_ack && !flush;
      post_cnt_s = {1'b0, fifo_count_s} + (CW+1)'(1) - {{CW{1'b0}}, pop_s};
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!nrst) state_r <= ST_IDLE;
      else       state_r <= state_nxt_s;
   end

   // FSM next state; a flushed in-flight request must still be drained via DROP.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!flush && (fifo_count_s < FULL_C)) state_nxt_s = ST_REQ;
            else                                   state_nxt_s = ST_IDLE;
         end
         ST_REQ: begin
            if (flush)         state_nxt_s = imem_ack ? ST_IDLE : ST_DROP;
            else if (imem_ack) state_nxt_s = (post_cnt_s < FULL_X) ? ST_REQ : ST_IDLE;
            else               state_nxt_s = ST_REQ;
         end
         ST_DROP: begin
            if (imem_ack) state_nxt_s = ST_IDLE;
            else          state_nxt_s = ST_DROP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Fetch address, plus the address of a request that is being dropped so the
   // memory sees a stable request while fetch_pc already points at the target.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         fetch_pc_r  <= RESET_PC;
         drop_addr_r <= RESET_PC;
      end else begin
         if (flush)       fetch_pc_r <= {flush_pc[XLEN-1:2], 2'b00};
         else if (push_s) fetch_pc_r <= fetch_pc_r + XLEN'(PC_STEP);
         else             fetch_pc_r <= fetch_pc_r;
         if ((state_r == ST_REQ) && flush && !imem_ack) drop_addr_r <= fetch_pc_r;
         else                                           drop_addr_r <= drop_addr_r;
      end
   end

   // FSM and queue-head outputs, all derived from registered state.
   always_comb begin
      imem_req = (state_r == ST_REQ) || (state_r == ST_DROP);
      case (state_r)
         ST_DROP: imem_addr = drop_addr_r;
         default: imem_addr = fetch_pc_r;
      endcase
      instr_valid = valid_s;
      if (valid_s) begin
         instr    = head_s[31+XLEN:XLEN];
         instr_pc = head_s[XLEN-1:0];
      end else begin
         instr    = 32'h0000_0000;
         instr_pc = {XLEN{1'b0}};
      end
   end

   assign count = fifo_count_s;

endmodule
